rng_health_monitor: RTL and testbench

Downstream consumer of the static statistics stage. Takes each analysed word with its four criterion flags (V1, Vcs, L0, L1) and grades it pass/fail. It runs a health FSM with warm-up, suspect and alarm states, and forwards only words graded in the healthy state through a small ready/valid FIFO. It also publishes a per-window pass count and a saturating drop counter for software.

---
 rtl/rng_health_pkg.sv | 23 ++
 rtl/health_fifo.sv | 80 ++++++++
 rtl/rng_health_monitor.sv | 170 +++++++++++++++++
 tb/tb_rng_health_monitor.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rng_health_pkg.sv
// rng_health_pkg
//   Shared types and helpers for the RNG health monitor.
//   - health_state_t : encoding of the health FSM state, also published on state_o
//   - grade_pass     : a word passes only when every criterion flag is set
package rng_health_pkg;

   typedef enum logic [1:0] {
      WARMUP  = 2'd0,
      OK      = 2'd1,
      SUSPECT = 2'd2,
      ALARM   = 2'd3
   } health_state_t;

   function automatic logic grade_pass(
      input logic v1_ok,
      input logic vcs_ok,
      input logic l0_ok,
      input logic l1_ok
   );
      return v1_ok & vcs_ok & l0_ok & l1_ok;
   endfunction

endpackage

// File: rtl/health_fifo.sv
// health_fifo
//   Synchronous FIFO, WORD_SIZE x DEPTH (DEPTH a power of 2, >= 2), with a
//   registered head word.
//   Ports:
//     clk, rst    clock and synchronous active-high reset
//     push, din   write request and data (ignored when full unless popping)
//     pop         read request (ignored when empty)
//     dout        registered head word, stable while not popped
//     valid       FIFO non-empty
//     full        FIFO holds DEPTH words
module health_fifo #(
   parameter int WORD_SIZE = 32,
   parameter int DEPTH     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [WORD_SIZE-1:0] din,
   input  logic                 pop,
   output logic [WORD_SIZE-1:0] dout,
   output logic                 valid,
   output logic                 full
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WORD_SIZE-1:0] mem [DEPTH];
   logic [AW-1:0]        rd_ptr;
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr_inc;
   logic [AW:0]          count;
   logic                 do_pop;
   logic                 do_push;

   assign valid      = (count != '0);
   assign full       = (count == (AW+1)'(DEPTH));
   assign do_pop     = pop & valid;
   // When full, a push is only taken if the head leaves on the same edge.
   assign do_push    = push & (~full | do_pop);
   assign rd_ptr_inc = rd_ptr + 1'b1;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         dout   <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr_inc;
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // Head register: next stored word after a pop, or the incoming word
         // when it becomes the new head (empty FIFO or last word leaving).
         if (do_pop) begin
            if (count > (AW+1)'(1)) begin
               dout <= mem[rd_ptr_inc];
            end else if (do_push) begin
               dout <= din;
            end
         end else if (do_push && !valid) begin
            dout <= din;
         end
      end
   end

endmodule

// File: rtl/rng_health_monitor.sv
// rng_health_monitor
//   Grades analysed RNG words, tracks source health with a
//   WARMUP/OK/SUSPECT/ALARM FSM and forwards words graded in OK through a
//   small ready/valid FIFO.
//   Ports:
//     clk, rst                       clock, synchronous active-high reset
//     in_valid, in_data              analysed word stream
//     v1_ok, vcs_ok, l0_ok, l1_ok    criterion flags aligned with in_data
//     out_valid, out_ready, out_data forwarded word stream (FIFO head)
//     alarm, state_o                 health status
//     drop_cnt                       saturating count of words lost to a full FIFO
//     win_pass, win_done             pass count of the last completed window + pulse
module rng_health_monitor
   import rng_health_pkg::*;
#(
   parameter int WORD_SIZE    = 32,
   parameter int WARMUP_WORDS = 4,
   parameter int FAIL_THR     = 3,
   parameter int RECOVER_THR  = 8,
   parameter int WIN          = 256,
   parameter int FIFO_DEPTH   = 4,
   parameter int CNT_W        = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [WORD_SIZE-1:0]       in_data,
   input  logic                       v1_ok,
   input  logic                       vcs_ok,
   input  logic                       l0_ok,
   input  logic                       l1_ok,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WORD_SIZE-1:0]       out_data,
   output logic                       alarm,
   output logic [1:0]                 state_o,
   output logic [CNT_W-1:0]           drop_cnt,
   output logic [$clog2(WIN+1)-1:0]   win_pass,
   output logic                       win_done
);

   localparam int WW = $clog2(WARMUP_WORDS + 1);
   localparam int FW = $clog2(FAIL_THR + 1);
   localparam int PW = $clog2(RECOVER_THR + 1);
   localparam int NW = $clog2(WIN + 1);

   localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_WORDS - 1);
   localparam logic [FW-1:0] FAIL_LAST = FW'(FAIL_THR - 1);
   localparam logic [PW-1:0] REC_LAST  = PW'(RECOVER_THR - 1);
   localparam logic [NW-1:0] WIN_LAST  = NW'(WIN - 1);

   health_state_t  state;
   logic [WW-1:0]  warm_cnt;
   logic [FW-1:0]  fail_cnt;
   logic [PW-1:0]  pass_cnt;
   logic [NW-1:0]  win_cnt;
   logic [NW-1:0]  acc;

   logic           pass;
   logic           graded;
   logic           forward;
   logic           fifo_full;
   logic           drop;

   assign pass    = grade_pass(v1_ok, vcs_ok, l0_ok, l1_ok);
   assign graded  = in_valid && (state != WARMUP);
   assign forward = in_valid && (state == OK) && pass;
   // A full FIFO still takes the word if the consumer pops on the same edge.
   assign drop    = forward && fifo_full && !out_ready;
   assign state_o = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= WARMUP;
         alarm    <= 1'b0;
         warm_cnt <= '0;
         fail_cnt <= '0;
         pass_cnt <= '0;
      end else if (in_valid) begin
         unique case (state)
            WARMUP: begin
               if (warm_cnt == WARM_LAST) begin
                  state    <= OK;
                  warm_cnt <= '0;
               end else begin
                  warm_cnt <= warm_cnt + 1'b1;
               end
            end
            OK: begin
               if (!pass) begin
                  state    <= SUSPECT;
                  fail_cnt <= FW'(1);
               end
            end
            SUSPECT: begin
               if (pass) begin
                  state    <= OK;
                  fail_cnt <= '0;
               end else if (fail_cnt == FAIL_LAST) begin
                  state    <= ALARM;
                  alarm    <= 1'b1;
                  fail_cnt <= fail_cnt + 1'b1;
                  pass_cnt <= '0;
               end else begin
                  fail_cnt <= fail_cnt + 1'b1;
               end
            end
            ALARM: begin
               if (!pass) begin
                  pass_cnt <= '0;
               end else if (pass_cnt == REC_LAST) begin
                  state    <= OK;
                  alarm    <= 1'b0;
                  fail_cnt <= '0;
                  pass_cnt <= '0;
               end else begin
                  pass_cnt <= pass_cnt + 1'b1;
               end
            end
            default: state <= WARMUP;
         endcase
      end
   end

   // Window statistics over graded words; win_pass includes the closing word.
   always_ff @(posedge clk) begin
      if (rst) begin
         win_cnt  <= '0;
         acc      <= '0;
         win_pass <= '0;
         win_done <= 1'b0;
      end else begin
         win_done <= 1'b0;
         if (graded) begin
            if (win_cnt == WIN_LAST) begin
               win_pass <= acc + NW'(pass);
               win_done <= 1'b1;
               win_cnt  <= '0;
               acc      <= '0;
            end else begin
               win_cnt <= win_cnt + 1'b1;
               acc     <= acc + NW'(pass);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt <= '0;
      end else if (drop && (drop_cnt != '1)) begin
         drop_cnt <= drop_cnt + 1'b1;
      end
   end

   health_fifo #(
      .WORD_SIZE (WORD_SIZE),
      .DEPTH     (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (forward),
      .din   (in_data),
      .pop   (out_ready),
      .dout  (out_data),
      .valid (out_valid),
      .full  (fifo_full)
   );

endmodule

// File: tb/tb_rng_health_monitor.sv
// tb_rng_health_monitor
//   Scoreboard bench: words expected at the output are queued when driven and
//   compared in order whenever the monitor sees a pop.
module tb_rng_health_monitor;

   localparam int WS    = 32;
   localparam int WIN   = 8;
   localparam int CNT_W = 16;
   localparam int NW    = $clog2(WIN + 1);

   localparam logic [3:0] P   = 4'b1111;
   localparam logic [3:0] FV1 = 4'b0111;
   localparam logic [3:0] FVC = 4'b1011;
   localparam logic [3:0] FL0 = 4'b1101;
   localparam logic [3:0] FL1 = 4'b1110;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic [WS-1:0]   in_data;
   logic            v1_ok, vcs_ok, l0_ok, l1_ok;
   logic            out_valid;
   logic            out_ready;
   logic [WS-1:0]   out_data;
   logic            alarm;
   logic [1:0]      state_o;
   logic [CNT_W-1:0] drop_cnt;
   logic [NW-1:0]   win_pass;
   logic            win_done;

   int n_checks = 0;
   int n_pass   = 0;
   logic [WS-1:0] sb [$];

   always #5 clk = ~clk;

   rng_health_monitor #(
      .WORD_SIZE    (WS),
      .WARMUP_WORDS (4),
      .FAIL_THR     (3),
      .RECOVER_THR  (8),
      .WIN          (WIN),
      .FIFO_DEPTH   (4),
      .CNT_W        (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .v1_ok     (v1_ok),
      .vcs_ok    (vcs_ok),
      .l0_ok     (l0_ok),
      .l1_ok     (l1_ok),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .alarm     (alarm),
      .state_o   (state_o),
      .drop_cnt  (drop_cnt),
      .win_pass  (win_pass),
      .win_done  (win_done)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Output monitor: a pop happens on the next edge whenever valid & ready here.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         check_val("sb_nonempty", sb.size() != 0, 1'b1);
         if (sb.size() != 0) begin
            logic [WS-1:0] exp_w;
            exp_w = sb.pop_front();
            check_val("out_data", out_data, exp_w);
            $display("rx data=%08h exp=%08h", out_data, exp_w);
         end
      end
   end

   // Drive one word; returns 1 time unit after the accepting edge.
   task automatic send(input logic [3:0] f, input bit fwd);
      logic [WS-1:0] d;
      d = $urandom;
      in_data = d;
      {v1_ok, vcs_ok, l0_ok, l1_ok} = f;
      in_valid = 1'b1;
      if (fwd) sb.push_back(d);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      $display("tx data=%08h flags=%b fwd=%0d state=%0d alarm=%0d drop=%0d", d, f, fwd, state_o, alarm, drop_cnt);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic warmup();
      for (int i = 0; i < 4; i++) begin
         send(P, 1'b0);
         check_val("warm_state", state_o, (i == 3) ? 2'd1 : 2'd0);
      end
      check_val("warm_no_fwd", out_valid, 1'b0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      {v1_ok, vcs_ok, l0_ok, l1_ok} = 4'b0000;

      // Reset values
      @(posedge clk); #1;
      check_val("rst_state", state_o, 2'd0);
      check_val("rst_alarm", alarm, 1'b0);
      check_val("rst_out_valid", out_valid, 1'b0);
      check_val("rst_out_data", out_data, '0);
      check_val("rst_drop", drop_cnt, '0);
      check_val("rst_win_pass", win_pass, '0);
      check_val("rst_win_done", win_done, 1'b0);
      rst = 1'b0;

      // Warm-up then first forwarded word
      warmup();
      send(P, 1'b1);
      check_val("first_fwd_valid", out_valid, 1'b1);
      check_val("first_fwd_data", out_data, sb[0]);
      idle(2);

      // Fail x3 -> ALARM, 8 passes -> OK, nothing forwarded
      for (int i = 0; i < 3; i++) begin
         send(FV1, 1'b0);
         check_val("t2_state", state_o, (i == 2) ? 2'd3 : 2'd2);
         check_val("t2_alarm", alarm, (i == 2) ? 1'b1 : 1'b0);
      end
      for (int i = 0; i < 8; i++) begin
         send(P, 1'b0);
         check_val("rec_state", state_o, (i == 7) ? 2'd1 : 2'd3);
         check_val("rec_alarm", alarm, (i == 7) ? 1'b0 : 1'b1);
      end
      check_val("alarm_no_fwd", out_valid, 1'b0);
      send(P, 1'b1);
      idle(2);

      // Fail then pass: back to OK, pass word dropped, next forwarded
      send(FL1, 1'b0);
      check_val("t3_suspect", state_o, 2'd2);
      send(P, 1'b0);
      check_val("t3_ok", state_o, 2'd1);
      check_val("t3_no_fwd", out_valid, 1'b0);
      send(P, 1'b1);
      idle(2);

      // Back-pressure: 4 held, 2 dropped
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) send(P, i < 4);
      check_val("bp_drop", drop_cnt, 16'd2);
      check_val("bp_valid", out_valid, 1'b1);
      check_val("bp_head_stable", out_data, sb[0]);
      // Pop and push on the same edge while full
      out_ready = 1'b1;
      send(P, 1'b1);
      check_val("bp_no_new_drop", drop_cnt, 16'd2);
      idle(6);
      check_val("bp_drained", out_valid, 1'b0);
      check_val("bp_sb_empty", sb.size(), 0);

      // Reset mid-operation: 3 words held, state SUSPECT
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(P, 1'b1);
      send(FL0, 1'b0);
      check_val("mid_suspect", state_o, 2'd2);
      check_val("mid_valid", out_valid, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      sb.delete();
      check_val("mid_rst_valid", out_valid, 1'b0);
      check_val("mid_rst_state", state_o, 2'd0);
      check_val("mid_rst_drop", drop_cnt, '0);
      rst = 1'b0;
      out_ready = 1'b1;

      // Window: P P P F P F P F -> 5 passes, then 8 fails -> 0
      warmup();
      begin
         logic [3:0] pat [8];
         bit         fw  [8];
         pat = '{P, P, P, FVC, P, FL0, P, FL1};
         fw  = '{1, 1, 1, 0, 0, 0, 0, 0};
         for (int i = 0; i < 8; i++) begin
            send(pat[i], fw[i]);
            check_val("win1_done", win_done, (i == 7) ? 1'b1 : 1'b0);
         end
      end
      check_val("win1_pass", win_pass, 4'd5);
      idle(1);
      check_val("win1_done_drop", win_done, 1'b0);
      for (int i = 0; i < 8; i++) begin
         send(FV1, 1'b0);
         check_val("win2_done", win_done, (i == 7) ? 1'b1 : 1'b0);
         if (i == 3) check_val("win_hold", win_pass, 4'd5);
      end
      check_val("win2_pass", win_pass, 4'd0);
      idle(3);
      check_val("final_sb_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
